// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter in front of a 1-cycle-latency 32-bit block RAM
//   clk, rst_n                      clock, synchronous active-low reset
//   i_req/i_addr -> i_ack/i_rdata   instruction fetch port (word reads, addr[1:0] ignored)
//   d_req/d_we/d_size/d_addr/d_wdata -> d_ack/d_err/d_rdata   data load/store port
//   mem_we/mem_addr/mem_data <- mem_out                       block RAM port
//   Define ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise data always wins.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int RAM_ADDR_WIDTH = 13
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_req,
   input  logic [31:0]               i_addr,
   output logic                      i_ack,
   output logic [31:0]               i_rdata,
   input  logic                      d_req,
   input  logic                      d_we,
   input  logic [1:0]                d_size,
   input  logic [31:0]               d_addr,
   input  logic [31:0]               d_wdata,
   output logic                      d_ack,
   output logic                      d_err,
   output logic [31:0]               d_rdata,
   output logic [3:0]                mem_we,
   output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]               mem_data,
   input  logic [31:0]               mem_out
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;
   logic [0:0]  state_q, state_d;
   logic        i_ack_q, i_ack_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
   logic        issue, sel_data, wide, misalign;
   logic [31:0] addr, wdat;
   logic [3:0]  be;
   logic        unused_addr;
`ifdef ARB_ROUND_ROBIN_EN
   logic        last_q, last_d;
   // last_q=1 means data was granted last; on contention the other port wins
   assign sel_data = d_req & (~i_req | ~last_q);
   assign last_d   = issue ? sel_data : last_q;
`else
   assign sel_data = d_req;
`endif
   assign issue    = rst_n & (state_q == IDLE) & (i_req | d_req);
   assign addr     = sel_data ? d_addr : i_addr;
   assign wide     = d_size[1];
   assign misalign = wide ? |d_addr[1:0] : (d_size[0] & d_addr[0]);
   assign be       = wide ? 4'hF : d_size[0] ? 4'b0011 << d_addr[1:0] : 4'b0001 << d_addr[1:0];
   assign wdat     = wide ? d_wdata : d_size[0] ? {2{d_wdata[15:0]}} : {4{d_wdata[7:0]}};
   // upper address bits alias onto the RAM
   assign unused_addr = ^addr[31:RAM_ADDR_WIDTH+2];
   always_comb begin
      mem_we   = (issue & sel_data & d_we & ~misalign) ? be : 4'd0;
      mem_addr = issue ? addr[RAM_ADDR_WIDTH+1:2] : '0;
      mem_data = (issue & sel_data) ? wdat : 32'd0;
      state_d  = issue ? WAIT : IDLE;
      i_ack_d  = issue & ~sel_data;
      d_ack_d  = issue & sel_data;
      d_err_d  = issue & sel_data & misalign;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         d_err_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         i_ack_q <= i_ack_d;
         d_ack_q <= d_ack_d;
         d_err_q <= d_err_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= last_d;
`endif
      end
   end
   // reset asserted during WAIT aborts the pending ack immediately
   assign i_ack   = i_ack_q & rst_n;
   assign d_ack   = d_ack_q & rst_n;
   assign d_err   = d_err_q & rst_n;
   assign i_rdata = mem_out;
   assign d_rdata = mem_out;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector bench for mem_arbiter with a behavioural 8K x 32 RAM
`timescale 1ns/1ps
module tb_mem_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [1:0]  d_size = 2'd0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic        i_ack, d_ack, d_err;
   logic [31:0] i_rdata, d_rdata, mem_data;
   logic [3:0]  mem_we;
   logic [12:0] mem_addr;
   logic [31:0] mem_out = '0;
   logic [31:0] ram [0:8191] = '{default: 32'h0};
   int checks = 0, failures = 0;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_data[b*8 +: 8];
      mem_out <= ram[mem_addr];
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  e_we;
      logic [12:0] e_addr;
      logic [31:0] e_data;
      logic [31:0] e_rdata;
      logic        e_err;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int n);
      @(posedge clk); #1;
      d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
      @(negedge clk);
      chk($sformatf("v%0d_mem_we", n), {28'd0, mem_we}, {28'd0, v.e_we});
      chk($sformatf("v%0d_mem_addr", n), {19'd0, mem_addr}, {19'd0, v.e_addr});
      chk($sformatf("v%0d_mem_data", n), mem_data, v.e_data);
      chk($sformatf("v%0d_issue_noack", n), {31'd0, d_ack}, 32'd0);
      @(posedge clk); #1;
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_d_ack", n), {31'd0, d_ack}, 32'd1);
      chk($sformatf("v%0d_i_ack", n), {31'd0, i_ack}, 32'd0);
      chk($sformatf("v%0d_d_err", n), {31'd0, d_err}, {31'd0, v.e_err});
      chk($sformatf("v%0d_d_rdata", n), d_rdata, v.e_rdata);
      chk($sformatf("v%0d_wait_we", n), {28'd0, mem_we}, 32'd0);
   endtask

   initial begin
      vec_t vt [16];
      vec_t vr;
      logic [7:0] got_d, got_i, exp_d, exp_i;
      vt[0]  = '{1, 2'b10, 32'h10,   32'hDEADBEEF, 4'hF, 13'h4, 32'hDEADBEEF, 32'h0,        0};
      vt[1]  = '{0, 2'b10, 32'h10,   32'h0,        4'h0, 13'h4, 32'h0,        32'hDEADBEEF, 0};
      vt[2]  = '{1, 2'b10, 32'h10,   32'h11223344, 4'hF, 13'h4, 32'h11223344, 32'hDEADBEEF, 0};
      vt[3]  = '{1, 2'b00, 32'h13,   32'h000000A5, 4'h8, 13'h4, 32'hA5A5A5A5, 32'h11223344, 0};
      vt[4]  = '{0, 2'b10, 32'h10,   32'h0,        4'h0, 13'h4, 32'h0,        32'hA5223344, 0};
      vt[5]  = '{1, 2'b01, 32'h12,   32'h0000BEEF, 4'hC, 13'h4, 32'hBEEFBEEF, 32'hA5223344, 0};
      vt[6]  = '{0, 2'b01, 32'h10,   32'h0,        4'h0, 13'h4, 32'h0,        32'hBEEF3344, 0};
      vt[7]  = '{1, 2'b01, 32'h21,   32'h00001234, 4'h0, 13'h8, 32'h12341234, 32'h0,        1};
      vt[8]  = '{0, 2'b10, 32'h20,   32'h0,        4'h0, 13'h8, 32'h0,        32'h0,        0};
      vt[9]  = '{1, 2'b10, 32'h22,   32'hFFFFFFFF, 4'h0, 13'h8, 32'hFFFFFFFF, 32'h0,        1};
      vt[10] = '{0, 2'b10, 32'h23,   32'h0,        4'h0, 13'h8, 32'h0,        32'h0,        1};
      vt[11] = '{1, 2'b11, 32'h30,   32'hCAFEF00D, 4'hF, 13'hC, 32'hCAFEF00D, 32'h0,        0};
      vt[12] = '{0, 2'b00, 32'h8031, 32'h0,        4'h0, 13'hC, 32'h0,        32'hCAFEF00D, 0};
      vt[13] = '{1, 2'b00, 32'h31,   32'h00000077, 4'h2, 13'hC, 32'h77777777, 32'hCAFEF00D, 0};
      vt[14] = '{0, 2'b10, 32'h30,   32'h0,        4'h0, 13'hC, 32'h0,        32'hCAFE770D, 0};
      vt[15] = '{0, 2'b01, 32'h31,   32'h0,        4'h0, 13'hC, 32'h0,        32'hCAFE770D, 1};

      // reset with both ports requesting a store/fetch: nothing may be granted or written
      i_req = 1'b1; i_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h10; d_wdata = 32'hFFFFFFFF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
         chk("rst_acks", {29'd0, i_ack, d_ack, d_err}, 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk("idle_mem_we", {28'd0, mem_we}, 32'd0);
      chk("idle_mem_addr", {19'd0, mem_addr}, 32'd0);
      chk("idle_mem_data", mem_data, 32'd0);
      chk("idle_acks", {29'd0, i_ack, d_ack, d_err}, 32'd0);

      for (int n = 0; n < 16; n++) run_vec(vt[n], n);

      // misaligned instruction fetch reads the containing word
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h13;
      @(negedge clk);
      chk("fetch_mem_addr", {19'd0, mem_addr}, 32'h4);
      chk("fetch_mem_we", {28'd0, mem_we}, 32'd0);
      @(posedge clk); #1;
      i_req = 1'b0;
      @(negedge clk);
      chk("fetch_i_ack", {31'd0, i_ack}, 32'd1);
      chk("fetch_d_ack", {31'd0, d_ack}, 32'd0);
      chk("fetch_i_rdata", i_rdata, 32'hBEEF3344);

      // both ports held high for 8 cycles
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h30;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h10;
      got_d = '0; got_i = '0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         got_d[c] = d_ack;
         got_i[c] = i_ack;
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = 8'b0010_0010; exp_i = 8'b1000_1000;
`else
      exp_d = 8'b1010_1010; exp_i = 8'b0000_0000;
`endif
      chk("contend_d_acks", {24'd0, got_d}, {24'd0, exp_d});
      chk("contend_i_acks", {24'd0, got_i}, {24'd0, exp_i});
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      chk("contend_idle_after", {29'd0, i_ack, d_ack, mem_we != 4'd0}, 32'd0);

      // reset during WAIT of a load; a store request held through reset must not write
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h30;
      @(negedge clk);
      chk("abort_issue_addr", {19'd0, mem_addr}, 32'hC);
      @(posedge clk); #1;
      rst_n = 1'b0; d_we = 1'b1; d_wdata = 32'h0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("abort_d_ack", {31'd0, d_ack}, 32'd0);
         chk("abort_mem_we", {28'd0, mem_we}, 32'd0);
         @(posedge clk); #1;
      end
      rst_n = 1'b1; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk("abort_released_idle", {29'd0, i_ack, d_ack, d_err}, 32'd0);
      vr = '{0, 2'b10, 32'h30, 32'h0, 4'h0, 13'hC, 32'h0, 32'hCAFE770D, 0};
      run_vec(vr, 99);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_ADDR_WIDTH, default 13, word-address width of the attached 32-bit block RAM (8K x 32).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port i_req  input  1  instruction-fetch request.
REQ-005 The block SHALL have port i_addr  input  32  fetch byte address.
REQ-006 The block SHALL have port i_ack  output  1  fetch completion pulse.
REQ-007 The block SHALL have port i_rdata  output  32  fetch word.
REQ-008 The block SHALL have port d_req  input  1  data request.
REQ-009 The block SHALL have port d_we  input  1  1=store, 0=load.
REQ-010 The block SHALL have port d_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-011 The block SHALL have port d_addr  input  32  data byte address.
REQ-012 The block SHALL have port d_wdata  input  32  store data, right-aligned.
REQ-013 The block SHALL have port d_ack  output  1  data completion pulse.
REQ-014 The block SHALL have port d_err  output  1  misaligned-access flag, valid with d_ack.
REQ-015 The block SHALL have port d_rdata  output  32  load word, unshifted.
REQ-016 The block SHALL have port mem_we  output  4  RAM byte write enables.
REQ-017 The block SHALL have port mem_addr  output  RAM_ADDR_WIDTH  RAM word address.
REQ-018 The block SHALL have port mem_data  output  32  RAM write data.
REQ-019 The block SHALL have port mem_out  input  32  RAM registered read data, 1-cycle latency.

Function
REQ-020 The FSM SHALL have states IDLE and WAIT: IDLE with any request -> grant, issue, go to WAIT; WAIT -> IDLE unconditionally after one cycle.
REQ-021 Requests SHALL be sampled only in IDLE; a req still high in the cycle after its ack SHALL start a new transaction.
REQ-022 The issue cycle SHALL drive mem_addr/mem_we/mem_data combinationally from the granted port; mem_addr = addr[RAM_ADDR_WIDTH+1:2]; upper address bits are ignored (aliasing).
REQ-023 The ack for the granted port SHALL be a registered one-cycle pulse in the WAIT cycle; i_rdata and d_rdata SHALL equal mem_out at all times, meaningful only with ack.
REQ-024 Latency SHALL be 2 cycles issue-to-ack; peak throughput SHALL be one access per 2 cycles.
REQ-025 Store enables SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads and fetches SHALL use mem_we=0.
REQ-026 Store data SHALL be replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-027 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) SHALL force mem_we=0, still perform the read, and assert d_err with d_ack.
REQ-028 While idle with no grant, mem_we SHALL be 0 and mem_addr/mem_data SHALL be 0.
REQ-029 Fetch misalignment SHALL be ignored (addr[1:0] dropped).

Reset
REQ-030 While rst_n=0, mem_we SHALL be forced to 0 combinationally and no request SHALL be granted.
REQ-031 On reset, state SHALL be IDLE and i_ack, d_ack, d_err SHALL be 0.
REQ-032 Reset during WAIT SHALL abort the transaction with no ack; a write already issued SHALL NOT be undone.

Configuration
REQ-033 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port not granted last; the last-grant register SHALL reset to instruction, so data wins the first contention.
REQ-034 Without ARB_ROUND_ROBIN_EN, data SHALL always win over instruction and no last-grant register SHALL exist.

Verification
REQ-035 Word store d_addr=0x10, d_wdata=0xDEADBEEF, then load 0x10 -> mem_we=4'hF, mem_addr=4, d_ack on cycle 2, d_rdata=0xDEADBEEF, d_err=0.
REQ-036 Byte store 0xA5 to 0x13 over word 0x11223344 -> mem_we=4'b1000, mem_data=0xA5A5A5A5, reread 0xA5223344.
REQ-037 Half store to 0x21 -> mem_we=0, d_ack with d_err=1, RAM word unchanged.
REQ-038 i_req and d_req held high for 8 cycles -> fixed build: 4 d_acks, 0 i_acks; round-robin build: acks alternate D,I,D,I.
REQ-039 rst_n low during WAIT of a load -> no d_ack, state IDLE, mem_we=0 throughout reset; the next request after release completes normally.
